// File: rtl/ccff_chain_prober.sv
// ccff_chain_prober: self-test engine for FPGA configuration chains on the
// prog_clk domain. Each run flushes every chain, drives a PULSE_LEN-cycle
// marker into ccff_head and times its arrival at ccff_tail. It reports the
// first-arrival cycle index and a per-chain pass/fail verdict.
//
// Optional feature macro: CCFF_PROBE_DUAL_POLARITY_EN
//   defined   : a second flush/inject/track pass follows with inverted levels
//               (flush with 1s, 0-marker). A chain must pass both passes.
//   undefined : single pass only.
//
// Handshake: start is a one-cycle request that is sampled only in IDLE.
// A request in any other state is dropped and never queued. busy is high
// for the whole run. done pulses for one cycle after busy falls. The
// verdicts (chain_ok, pass) update in that done cycle. They hold until the
// next accepted start.
module ccff_chain_prober #(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN  = 29696,
  parameter int PULSE_LEN  = 1,
  parameter int MARGIN     = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        prog_clk,
  input  logic                        prog_reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [NUM_CHAINS-1:0]       chain_ok,
  output logic [NUM_CHAINS*CNT_W-1:0] meas_len,
  output logic [NUM_CHAINS-1:0]       ccff_head,
  input  logic [NUM_CHAINS-1:0]       ccff_tail,
  output logic [2:0]                  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_INJECT = 3'd2,
    S_TRACK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Last counter value of each phase, and the window in which the marker must be seen.
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] INJ_LAST   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] TRACK_LAST = CNT_W'(CHAIN_LEN + PULSE_LEN + MARGIN - 1);
  localparam logic [CNT_W-1:0] WIN_LO     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WIN_HI     = CNT_W'(CHAIN_LEN + PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pol;        // level polarity of the current pass
  logic                    pol_next;   // polarity the next state will run with
  logic                    last_pass;  // TRACK of this pass ends the run
  logic                    sampling;
  logic                    in_win;
  logic                    exp_lvl;
  logic                    mark_lvl;
  logic                    head_lvl_d;
  logic [NUM_CHAINS-1:0]   match;
  logic [NUM_CHAINS-1:0]   hit;
  logic [NUM_CHAINS-1:0]   ok_acc;

`ifdef CCFF_PROBE_DUAL_POLARITY_EN
  logic pol_q;
  logic pol_d;

  // Pass selector: a run starts in pass 1; it switches to pass 2 when TRACK loops back to FLUSH.
  always_comb begin
    pol_d = pol_q;
    if (state_q == S_IDLE) pol_d = 1'b0;
    else if (state_q == S_TRACK && state_d == S_FLUSH) pol_d = 1'b1;
  end

  // Pass register.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) pol_q <= 1'b0;
    else            pol_q <= pol_d;
  end

  assign pol       = pol_q;
  assign pol_next  = pol_d;
  assign last_pass = pol_q;
`else
  assign pol       = 1'b0;
  assign pol_next  = 1'b0;
  assign last_pass = 1'b1;
`endif

  // State register.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: phase lengths are timed by the shared counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FLUSH;
      S_FLUSH:  if (cnt_q == FLUSH_LAST) state_d = S_INJECT;
      S_INJECT: if (cnt_q == INJ_LAST) state_d = S_TRACK;
      S_TRACK:  if (cnt_q == TRACK_LAST) state_d = last_pass ? S_DONE : S_FLUSH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode of the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_FLUSH, S_INJECT, S_TRACK: busy = 1'b1;
      S_DONE:                     done = 1'b1;
      default:                    ;
    endcase
  end

  assign state_dbg = state_q;

  // Phase counter. It restarts at FLUSH and INJECT entry, runs on through TRACK as k, and saturates.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cnt_q <= '0;
    end else if ((state_d == S_FLUSH && state_q != S_FLUSH) ||
                 (state_d == S_INJECT && state_q != S_INJECT) ||
                 state_d == S_IDLE || state_d == S_DONE) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Head level for the state about to be entered, so the registered head lines up with the state.
  always_comb begin
    head_lvl_d = 1'b0;
    case (state_d)
      S_FLUSH:  head_lvl_d = pol_next;
      S_INJECT: head_lvl_d = ~pol_next;
      S_TRACK:  head_lvl_d = pol_next;
      default:  head_lvl_d = 1'b0;
    endcase
  end

  // Registered head drive.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) ccff_head <= '0;
    else            ccff_head <= {NUM_CHAINS{head_lvl_d}};
  end

  assign sampling = (state_q == S_INJECT) || (state_q == S_TRACK);
  assign in_win   = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  assign exp_lvl  = in_win ^ pol;
  assign mark_lvl = ~pol;

  // Per-chain tail compare. A tail that is not exactly the expected level (X/Z included) fails.
  always_comb begin
    match = '1;
    hit   = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (sampling) begin
        if (ccff_tail[i] == exp_lvl) match[i] = 1'b1;
        else                         match[i] = 1'b0;
        if (ccff_tail[i] == mark_lvl) hit[i] = 1'b1;
      end
    end
  end

  // Result tracking: clear on an accepted start, accumulate while sampling, publish the verdict on DONE entry.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain_ok <= '0;
      pass     <= 1'b0;
      meas_len <= '1;
      ok_acc   <= '0;
    end else if (state_q == S_IDLE && start) begin
      chain_ok <= '0;
      pass     <= 1'b0;
      meas_len <= '1;
      ok_acc   <= '1;
    end else if (sampling) begin
      ok_acc <= ok_acc & match;
      for (int i = 0; i < NUM_CHAINS; i++) begin
        if (hit[i] && meas_len[i*CNT_W +: CNT_W] == '1) meas_len[i*CNT_W +: CNT_W] <= cnt_q;
      end
      if (state_d == S_DONE) begin
        chain_ok <= ok_acc & match;
        pass     <= &(ok_acc & match);
      end
    end
  end

endmodule
